muldiv_sequencer: RTL

//  Multi-cycle RV64M multiply/divide unit sequenced beside the execute-stage ALU.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_dp.sv | 140 ++++++++++++++
 rtl/muldiv_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_DATA_WIDTH = 64;
    localparam int MD_CNT_WIDTH  = $clog2(MD_DATA_WIDTH);

    // func3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/muldiv_dp.sv
// rtl/muldiv_dp.sv - operand, accumulator and remainder registers around one shared add/sub
//
// Ports:
//   i_clk, i_arst_n      clock, synchronous active-low reset
//   i_load               latch i_op / i_src_1 / i_src_2
//   i_prep               form operand magnitudes and the result sign
//   i_step               one shift-add (multiply) or restoring-divide iteration
//   i_fixup              sign-correct and select the final result into o_result
//   i_load_fast          load i_fast_data directly into o_result
//   o_result             registered result, held until the next load
module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_load,
    input  op_e                   i_op,
    input  logic [DATA_WIDTH-1:0] i_src_1,
    input  logic [DATA_WIDTH-1:0] i_src_2,
    input  logic                  i_prep,
    input  logic                  i_step,
    input  logic                  i_fixup,
    input  logic                  i_load_fast,
    input  logic [DATA_WIDTH-1:0] i_fast_data,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int DW = DATA_WIDTH;

    op_e           r_op;
    logic [DW-1:0] r_src_1;
    logic [DW-1:0] r_src_2;
    logic [DW-1:0] r_a;       // multiplicand / divisor magnitude
    logic [DW-1:0] r_lo;      // multiplier shifting into product low / dividend shifting into quotient
    logic [DW:0]   r_rem;     // product high / partial remainder
    logic          r_neg;     // negate the selected result in FIXUP
    logic [DW-1:0] r_result;

    logic          w_is_div;
    logic          w_s1_signed;
    logic          w_s2_signed;
    logic          w_neg_1;
    logic          w_neg_2;
    logic [DW-1:0] w_mag_1;
    logic [DW-1:0] w_mag_2;
    logic          w_neg_res;
    logic [DW:0]   w_rem_sh;
    logic [DW:0]   w_add_a;
    logic [DW:0]   w_add_b;
    logic          w_cin;
    logic [DW:0]   w_sum;
    logic [2*DW-1:0] w_prod;
    logic [2*DW-1:0] w_prod_fix;
    logic [DW-1:0] w_fix_result;

    assign w_is_div    = r_op[2];
    assign w_s1_signed = (r_op == OP_MULH) || (r_op == OP_MULHSU) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_s2_signed = (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_neg_1     = w_s1_signed & r_src_1[DW-1];
    assign w_neg_2     = w_s2_signed & r_src_2[DW-1];
    assign w_mag_1     = w_neg_1 ? -r_src_1 : r_src_1;
    assign w_mag_2     = w_neg_2 ? -r_src_2 : r_src_2;

    // Remainder follows the dividend; quotient sign is suppressed on divide-by-zero
    // so the all-ones quotient of the restoring loop passes through untouched.
    always_comb begin
        w_neg_res = w_neg_1 ^ w_neg_2;
        if (r_op == OP_REM || r_op == OP_REMU) begin
            w_neg_res = w_neg_1;
        end else if (w_is_div) begin
            w_neg_res = (w_neg_1 ^ w_neg_2) & (r_src_2 != '0);
        end
    end

    // Shared adder: multiply adds the multiplicand when the multiplier LSB is set,
    // divide subtracts the divisor from the shifted remainder (invert + carry-in).
    assign w_rem_sh = {r_rem[DW-1:0], r_lo[DW-1]};
    assign w_add_a  = w_is_div ? w_rem_sh : r_rem;
    assign w_add_b  = w_is_div ? ~{1'b0, r_a} : (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_cin    = w_is_div;
    assign w_sum    = w_add_a + w_add_b + {{DW{1'b0}}, w_cin};

    assign w_prod     = {r_rem[DW-1:0], r_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                       w_fix_result = w_prod_fix[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fix[2*DW-1:DW];
            OP_DIV, OP_DIVU:              w_fix_result = r_neg ? -r_lo : r_lo;
            default:                      w_fix_result = r_neg ? -r_rem[DW-1:0] : r_rem[DW-1:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_op     <= OP_MUL;
            r_src_1  <= '0;
            r_src_2  <= '0;
            r_a      <= '0;
            r_lo     <= '0;
            r_rem    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_op    <= i_op;
                r_src_1 <= i_src_1;
                r_src_2 <= i_src_2;
            end
            if (i_prep) begin
                r_a   <= w_mag_2;
                r_lo  <= w_mag_1;
                r_rem <= '0;
                r_neg <= w_neg_res;
            end
            if (i_step) begin
                if (w_is_div) begin
                    // sum bit DW set means the trial subtraction went negative: restore
                    r_rem <= w_sum[DW] ? w_rem_sh : w_sum;
                    r_lo  <= {r_lo[DW-2:0], ~w_sum[DW]};
                end else begin
                    r_rem <= {1'b0, w_sum[DW:1]};
                    r_lo  <= {w_sum[0], r_lo[DW-1:1]};
                end
            end
            if (i_fixup) begin
                r_result <= w_fix_result;
            end else if (i_load_fast) begin
                r_result <= i_fast_data;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV64M multiply/divide sequencer with pipeline stall
//
// Optional feature macro: MULDIV_FAST_ZERO_EN (zero-operand ops complete one cycle after accept)
//
// Ports:
//   i_clk, i_arst_n   clock, synchronous active-low reset
//   i_start           M-extension op present in execute (held while stalled)
//   i_op              func3 of the op
//   i_src_1, i_src_2  forwarded rs1 / rs2
//   i_flush           abort any operation in flight
//   o_stall           freeze fetch/decode/execute
//   o_valid           one-cycle pulse, o_result valid
//   o_result          registered result
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH,
    parameter int CNT_WIDTH  = MD_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_src_1,
    input  logic [DATA_WIDTH-1:0] i_src_2,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result
);

    state_e               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_valid;

    logic                  w_accept;
    logic                  w_busy;
    logic                  w_fast_hit;
    logic [DATA_WIDTH-1:0] w_fast_data;

    assign w_accept = (r_state == ST_IDLE) & i_start & ~i_flush;
    assign w_busy   = (r_state == ST_PREP) | (r_state == ST_CALC) | (r_state == ST_FIXUP);

`ifdef MULDIV_FAST_ZERO_EN
    // Zero divisor, or a zero factor on a multiply, has a result known from the inputs alone.
    assign w_fast_hit = (i_src_2 == '0) || ((i_src_1 == '0) && !i_op[2]);
    always_comb begin
        w_fast_data = '0;
        if (i_op[2]) begin
            w_fast_data = i_op[1] ? i_src_1 : '1;
        end
    end
`else
    assign w_fast_hit  = 1'b0;
    assign w_fast_data = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_fast_hit) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    r_cnt   <= '0;
                    r_state <= i_flush ? ST_IDLE : ST_CALC;
                end
                ST_CALC: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        r_state <= ST_FIXUP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_FIXUP: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    muldiv_dp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dp (
        .i_clk       (i_clk),
        .i_arst_n    (i_arst_n),
        .i_load      (w_accept),
        .i_op        (op_e'(i_op)),
        .i_src_1     (i_src_1),
        .i_src_2     (i_src_2),
        .i_prep      ((r_state == ST_PREP) & ~i_flush),
        .i_step      ((r_state == ST_CALC) & ~i_flush),
        .i_fixup     ((r_state == ST_FIXUP) & ~i_flush),
        .i_load_fast (w_accept & w_fast_hit),
        .i_fast_data (w_fast_data),
        .o_result    (o_result)
    );

    // Stall drops immediately on flush and in DONE so the pipeline advances with the result.
    assign o_stall = w_accept | (w_busy & ~i_flush);
    assign o_valid = r_valid;

endmodule
